bridge_ndev: RTL

- Parametrised CPU-to-peripheral bridge for the MIPS system.
- Decodes a processor access against N_DEV address windows and forwards it to the selected device with a select/ack handshake.
- Returns registered read data, flags unmapped or timed-out accesses as bus errors, and synchronises device interrupt lines into the CPU hw_int vector.
- Sits between the CPU memory stage and the timers and other devices; replaces the fixed two-device combinational bridge.

---
 rtl/bridge_pkg.sv | 18 +
 rtl/bridge_ndev_if.sv | 44 ++++
 rtl/bridge_decode.sv | 24 ++
 rtl/bridge_ndev.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM encoding and
// the fixed widths of the address window and interrupt vector.
package bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Each device window is 16 bytes; PrAddr[31:4] selects the window.
   localparam int WIN_OFF_W = 4;
   localparam int WIN_W     = 32 - WIN_OFF_W;

   // Width of the CPU hardware interrupt vector.
   localparam int HWINT_W   = 6;

endpackage

// File: rtl/bridge_ndev_if.sv
// Bus bundle between the CPU memory stage, the bridge and its devices.
// The bridge uses the slave view; the CPU/device side uses the master view.
interface bridge_ndev_if #(
   parameter int N_DEV = 3
) ();

   // CPU side
   logic                          PrReq;
   logic [31:0]                   PrAddr;
   logic [31:0]                   PrWD;
   logic                          PrWE;
   logic                          PrBusy;
   logic                          PrRdy;
   logic [31:0]                   PrRD;
   logic                          PrErr;
   logic [31:0]                   ErrAddr;

   // Device side
   logic [31:0]                   DEVAddr;
   logic [31:0]                   DEVWD;
   logic [N_DEV-1:0]              DEVSel;
   logic [N_DEV-1:0]              DEVWE;
   logic [N_DEV*32-1:0]           DEVRD;
   logic [N_DEV-1:0]              DEVAck;
   logic [N_DEV-1:0]              DEVIrq;
   logic [bridge_pkg::HWINT_W-1:0] HWInt;

   modport slave (
      input  PrReq, PrAddr, PrWD, PrWE,
      output PrBusy, PrRdy, PrRD, PrErr, ErrAddr,
      output DEVAddr, DEVWD, DEVSel, DEVWE,
      input  DEVRD, DEVAck, DEVIrq,
      output HWInt
   );

   modport master (
      output PrReq, PrAddr, PrWD, PrWE,
      input  PrBusy, PrRdy, PrRD, PrErr, ErrAddr,
      input  DEVAddr, DEVWD, DEVSel, DEVWE,
      output DEVRD, DEVAck, DEVIrq,
      input  HWInt
   );

endinterface

// File: rtl/bridge_decode.sv
// Address window decoder: maps PrAddr[31:4] to a one-hot device hit.
// When several windows carry the same base, the lowest index wins.
module bridge_decode
   import bridge_pkg::*;
#(
   parameter int                     N_DEV    = 3,
   parameter logic [N_DEV*WIN_W-1:0] DEV_BASE = {28'h00007F2, 28'h00007F1, 28'h00007F0}
) (
   input  logic [WIN_W-1:0] win_i,
   output logic [N_DEV-1:0] hit_o
);

   // Scan from the top index down so a lower matching index overrides
   always_comb begin
      hit_o = '0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if (win_i == DEV_BASE[i*WIN_W +: WIN_W]) begin
            hit_o    = '0;
            hit_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bridge_ndev.sv
// CPU-to-peripheral bridge: decodes a CPU access against N_DEV windows,
// runs a select/ack handshake with the chosen device (bounded by TIMEOUT),
// returns registered read data with an error flag, and registers the
// device interrupt lines into the CPU hardware interrupt vector.
module bridge_ndev
   import bridge_pkg::*;
#(
   parameter int                     N_DEV    = 3,
   parameter logic [N_DEV*WIN_W-1:0] DEV_BASE = {28'h00007F2, 28'h00007F1, 28'h00007F0},
   parameter int                     TIMEOUT  = 8,
   parameter logic [31:0]            MISS_RD  = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   bridge_ndev_if.slave bus
);

   // Counter only has to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wd_q, wd_d;
   logic [31:0]          rd_q, rd_d;
   logic                 err_q, err_d;
   logic [31:0]          erraddr_q, erraddr_d;
   logic [N_DEV-1:0]     sel_q, sel_d;
   logic [N_DEV-1:0]     we_q, we_d;
   logic [HWINT_W-1:0]   hwint_q, hwint_d;

   logic [N_DEV-1:0]     hit;
   logic                 ack_sel;
   logic [31:0]          rd_sel;

   bridge_decode #(
      .N_DEV    (N_DEV),
      .DEV_BASE (DEV_BASE)
   ) u_decode (
      .win_i (bus.PrAddr[31:WIN_OFF_W]),
      .hit_o (hit)
   );

   // Ack and read data of the currently selected device only
   always_comb begin
      ack_sel = |(bus.DEVAck & sel_q);
      rd_sel  = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (sel_q[i]) begin
            rd_sel = rd_sel | bus.DEVRD[i*32 +: 32];
         end
      end
   end

   // Next-state and response-register update for the access FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wd_d      = wd_q;
      rd_d      = rd_q;
      err_d     = err_q;
      erraddr_d = erraddr_q;
      sel_d     = sel_q;
      we_d      = '0;   // write strobe lasts a single ACCESS cycle

      case (state_q)
         ST_IDLE: begin
            if (bus.PrReq) begin
               addr_d = bus.PrAddr;
               wd_d   = bus.PrWD;
               cnt_d  = '0;
               if (|hit) begin
                  state_d = ST_ACCESS;
                  sel_d   = hit;
                  we_d    = bus.PrWE ? hit : '0;
               end else begin
                  // Unmapped: answer directly without touching any device
                  state_d   = ST_RESP;
                  err_d     = 1'b1;
                  rd_d      = MISS_RD;
                  erraddr_d = bus.PrAddr;
               end
            end
         end

         ST_ACCESS: begin
            if (ack_sel) begin
               // Data is captured for writes as well; the CPU ignores it
               state_d = ST_RESP;
               sel_d   = '0;
               rd_d    = rd_sel;
               err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = ST_RESP;
               sel_d     = '0;
               err_d     = 1'b1;
               rd_d      = MISS_RD;
               erraddr_d = addr_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // FSM state and response registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wd_q      <= '0;
         rd_q      <= '0;
         err_q     <= 1'b0;
         erraddr_q <= '0;
         sel_q     <= '0;
         we_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         rd_q      <= rd_d;
         err_q     <= err_d;
         erraddr_q <= erraddr_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
      end
   end

   // Interrupt vector: device lines in the low bits, unused bits zero
   always_comb begin
      hwint_d              = '0;
      hwint_d[N_DEV-1:0]   = bus.DEVIrq;
   end

   // One-flop interrupt register, independent of the access FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         hwint_q <= '0;
      end else begin
         hwint_q <= hwint_d;
      end
   end

   assign bus.PrBusy  = (state_q != ST_IDLE);
   assign bus.PrRdy   = (state_q == ST_RESP);
   assign bus.PrRD    = rd_q;
   assign bus.PrErr   = err_q;
   assign bus.ErrAddr = erraddr_q;
   assign bus.DEVAddr = addr_q;
   assign bus.DEVWD   = wd_q;
   assign bus.DEVSel  = sel_q;
   assign bus.DEVWE   = we_q;
   assign bus.HWInt   = hwint_q;

endmodule
